turbo_iteration_scheduler: RTL and testbench

Control FSM that time-shares one `bcjr_max_product` instance between the two constituent decoders of a turbo decoder. It accepts one frame at a time and issues half-iterations: natural order (`dec_sel`=0), then interleaved order (`dec_sel`=1). It waits for each decoder result, gates the extrinsic-memory write, and counts full iterations. It stops at `ITERATIONS`, on a decoder timeout, or, optionally, on an early-stop request. It drives control only; LLR and extrinsic data paths stay outside this block.

---
 rtl/turbo_iteration_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_turbo_iteration_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_iteration_scheduler.sv
// turbo_iteration_scheduler
//
// Control FSM that time-shares one max-product BCJR decoder between the two
// constituent decoders of a turbo decoder. One frame is taken at a time.
// Each full iteration is two half-iterations: natural order (dec_sel=0), then
// interleaved order (dec_sel=1). The block waits for each decoder result,
// gates the extrinsic-memory write and counts full iterations. A frame ends
// after ITERATIONS iterations, on a decoder timeout, or on an early-stop
// request when that feature is built in. Only control is driven here; the LLR
// and extrinsic data paths live outside this block.
//
// Build option:
//   TURBO_EARLY_STOP_EN - when defined, stop_req sampled at an interleaved
//                         (dec_sel=1) completion ends the frame. When
//                         undefined, stop_req is unused.
//
// Parameters:
//   ITERATIONS  - full iterations per frame (1 .. 2**ITER_BITS-1)
//   ITER_BITS   - width of the iteration counter and out_iters
//   LATENCY_MAX - WAIT cycles allowed per half-iteration (>= 2)
//
// Ports:
//   clk           - clock, rising edge
//   reset         - synchronous, active-high
//   frame_valid   - a loaded frame is ready to decode
//   frame_ready   - high in IDLE only
//   dec_in_valid  - one-cycle decoder start pulse
//   dec_sel       - 0 natural order, 1 interleaved; stable ISSUE..WAIT
//   apriori_zero  - with dec_in_valid on the first half-iteration only
//   dec_out_valid - decoder result valid
//   ext_we        - extrinsic-memory write enable (WAIT only)
//   stop_req      - early-stop request from the CRC/convergence check
//   busy          - high in any state other than IDLE
//   out_valid     - one-cycle frame-complete pulse
//   out_iters     - completed full iterations, valid with out_valid
//   timeout_err   - with out_valid: the frame aborted on timeout

module turbo_iteration_scheduler #(
    parameter int ITERATIONS  = 8,
    parameter int ITER_BITS   = 4,
    parameter int LATENCY_MAX = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic                 dec_in_valid,
    output logic                 dec_sel,
    output logic                 apriori_zero,
    input  logic                 dec_out_valid,
    output logic                 ext_we,
    input  logic                 stop_req,
    output logic                 busy,
    output logic                 out_valid,
    output logic [ITER_BITS-1:0] out_iters,
    output logic                 timeout_err
);

    localparam int WAIT_BITS = $clog2(LATENCY_MAX);

    localparam logic [WAIT_BITS-1:0] WAIT_LIMIT = WAIT_BITS'(LATENCY_MAX - 1);
    localparam logic [ITER_BITS-1:0] ITER_LAST  = ITER_BITS'(ITERATIONS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               state, state_next;
    logic [ITER_BITS-1:0] iter_cnt, iter_cnt_next, iter_inc;
    logic [WAIT_BITS-1:0] wait_cnt, wait_cnt_next;
    logic                 sel, sel_next;
    logic                 first, first_next;
    logic                 to_flag, to_flag_next;
    logic                 early_stop;

`ifdef TURBO_EARLY_STOP_EN
    assign early_stop = stop_req;
`else
    logic unused_stop_req;
    assign unused_stop_req = stop_req;
    assign early_stop      = 1'b0;
`endif

    assign dec_sel  = sel;
    assign iter_inc = iter_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            iter_cnt <= '0;
            wait_cnt <= '0;
            sel      <= 1'b0;
            first    <= 1'b0;
            to_flag  <= 1'b0;
        end else begin
            state    <= state_next;
            iter_cnt <= iter_cnt_next;
            wait_cnt <= wait_cnt_next;
            sel      <= sel_next;
            first    <= first_next;
            to_flag  <= to_flag_next;
        end
    end

    always_comb begin
        state_next    = state;
        iter_cnt_next = iter_cnt;
        wait_cnt_next = wait_cnt;
        sel_next      = sel;
        first_next    = first;
        to_flag_next  = to_flag;

        frame_ready   = 1'b0;
        dec_in_valid  = 1'b0;
        apriori_zero  = 1'b0;
        ext_we        = 1'b0;
        busy          = 1'b1;
        out_valid     = 1'b0;
        out_iters     = '0;
        timeout_err   = 1'b0;

        case (state)
            S_IDLE: begin
                frame_ready = 1'b1;
                busy        = 1'b0;
                if (frame_valid) begin
                    state_next    = S_ISSUE;
                    iter_cnt_next = '0;
                    sel_next      = 1'b0;
                    to_flag_next  = 1'b0;
                    first_next    = 1'b1;
                end
            end

            S_ISSUE: begin
                dec_in_valid  = 1'b1;
                apriori_zero  = first;
                first_next    = 1'b0;
                wait_cnt_next = '0;
                state_next    = S_WAIT;
            end

            S_WAIT: begin
                wait_cnt_next = wait_cnt + 1'b1;
                ext_we        = dec_out_valid;
                // A result arriving on the limit cycle takes priority over the timeout.
                if (dec_out_valid) begin
                    if (!sel) begin
                        sel_next   = 1'b1;
                        state_next = S_ISSUE;
                    end else begin
                        iter_cnt_next = iter_inc;
                        if (iter_inc == ITER_LAST || early_stop) begin
                            state_next = S_DONE;
                        end else begin
                            sel_next   = 1'b0;
                            state_next = S_ISSUE;
                        end
                    end
                end else if (wait_cnt == WAIT_LIMIT) begin
                    to_flag_next = 1'b1;
                    state_next   = S_DONE;
                end
            end

            S_DONE: begin
                out_valid   = 1'b1;
                out_iters   = iter_cnt;
                timeout_err = to_flag;
                state_next  = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_turbo_iteration_scheduler.sv
// Self-checking bench for turbo_iteration_scheduler.
// Each frame's decoder latencies and stop_req levels are drawn up front; a
// schedule model then derives, per cycle offset from frame acceptance, when
// each output is expected to fire, and the run is compared cycle by cycle.

module tb_turbo_iteration_scheduler;

    localparam int ITER  = 3;
    localparam int IB    = 3;
    localparam int LMAX  = 12;
    localparam int NHALF = 2 * ITER;
    localparam int MAXC  = 128;
`ifdef TURBO_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_valid;
    logic          frame_ready;
    logic          dec_in_valid;
    logic          dec_sel;
    logic          apriori_zero;
    logic          dec_out_valid;
    logic          ext_we;
    logic          stop_req;
    logic          busy;
    logic          out_valid;
    logic [IB-1:0] out_iters;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Stimulus and expectations, indexed by cycle offset from acceptance (offset 0).
    bit d_dov [MAXC];
    bit d_stop[MAXC];
    bit d_fv  [MAXC];
    bit e_div [MAXC];
    bit e_apz [MAXC];
    bit e_we  [MAXC];
    bit e_sel [MAXC];
    int iss   [NHALF];
    int lat   [NHALF];
    int n_iss;
    int done_o;
    int e_iters;
    bit e_to;

    always #5 clk = ~clk;

    turbo_iteration_scheduler #(
        .ITERATIONS (ITER),
        .ITER_BITS  (IB),
        .LATENCY_MAX(LMAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .dec_in_valid (dec_in_valid),
        .dec_sel      (dec_sel),
        .apriori_zero (apriori_zero),
        .dec_out_valid(dec_out_valid),
        .ext_we       (ext_we),
        .stop_req     (stop_req),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_iters    (out_iters),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected schedule: half k issues at t, its result lands at t+lat (lat in
    // 1..LMAX), the next issue follows one cycle later. lat==0 means the
    // decoder never answers: DONE comes LMAX+1 cycles after the issue.
    task automatic build_model();
        int t;
        int r;
        bit fin;
        for (int o = 0; o < MAXC; o++) begin
            e_div[o] = 1'b0;
            e_apz[o] = 1'b0;
            e_we[o]  = 1'b0;
            e_sel[o] = 1'b0;
        end
        t       = 1;
        fin     = 1'b0;
        n_iss   = 0;
        done_o  = 0;
        e_iters = 0;
        e_to    = 1'b0;
        for (int k = 0; k < NHALF && !fin; k++) begin
            iss[k]   = t;
            n_iss    = k + 1;
            e_div[t] = 1'b1;
            if (k == 0) e_apz[t] = 1'b1;
            if (lat[k] == 0) begin
                for (int o = t; o <= t + LMAX; o++) e_sel[o] = bit'(k % 2);
                done_o  = t + LMAX + 1;
                e_iters = k / 2;
                e_to    = 1'b1;
                fin     = 1'b1;
            end else begin
                r = t + lat[k];
                for (int o = t; o <= r; o++) e_sel[o] = bit'(k % 2);
                d_dov[r] = 1'b1;
                e_we[r]  = 1'b1;
                if (k % 2 == 1 && ((k + 1) / 2 == ITER || (EARLY && d_stop[r]))) begin
                    done_o  = r + 1;
                    e_iters = (k + 1) / 2;
                    fin     = 1'b1;
                end
                t = r + 1;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_frame_ready"}, frame_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dec_in_valid"}, dec_in_valid, 0);
        check({tag, "_apriori_zero"}, apriori_zero, 0);
        check({tag, "_ext_we"}, ext_we, 0);
        check({tag, "_out_valid"}, out_valid, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            frame_valid   = 1'b0;
            dec_out_valid = 1'(($urandom & 1));
            stop_req      = 1'(($urandom & 1));
            @(negedge clk);
            check_idle("idle");
            next_cycle();
        end
    endtask

    // mode: 0 random, 1 all results at LMAX, 2 first half times out,
    //       3 reset during iteration 3, 4 stop_req held high, 5 latency 1
    task automatic run_frame(input int mode, input bit hold);
        int rst_at;
        int rv;
        for (int o = 0; o < MAXC; o++) begin
            d_dov[o]  = 1'b0;
            d_stop[o] = ($urandom_range(0, 3) == 0);
            if (mode == 1 || mode == 3) d_stop[o] = 1'b0;
            if (mode == 4) d_stop[o] = 1'b1;
            d_fv[o] = hold ? 1'b1 : 1'(($urandom & 1));
        end
        d_fv[0] = 1'b1;
        for (int k = 0; k < NHALF; k++) begin
            case (mode)
                1, 3:    lat[k] = LMAX;
                2:       lat[k] = (k == 0) ? 0 : 1;
                4:       lat[k] = int'($urandom_range(1, LMAX));
                5:       lat[k] = 1;
                default: begin
                    rv = int'($urandom_range(0, 19));
                    if (rv == 0)     lat[k] = 0;
                    else if (rv < 4) lat[k] = LMAX;
                    else             lat[k] = int'($urandom_range(1, LMAX));
                end
            endcase
        end
        build_model();
        // Stray results outside WAIT must have no effect.
        d_dov[0]      = 1'(($urandom & 1));
        d_dov[done_o] = 1'(($urandom & 1));
        for (int k = 0; k < n_iss; k++) begin
            if ($urandom_range(0, 2) == 0) d_dov[iss[k]] = 1'b1;
        end
        rst_at = (mode == 3) ? iss[4] + 3 : -1;

        for (int o = 0; o <= done_o; o++) begin
            if (o == rst_at) begin
                reset         = 1'b1;
                frame_valid   = 1'b0;
                dec_out_valid = 1'b0;
                stop_req      = 1'b0;
                next_cycle();
                reset         = 1'b0;
                dec_out_valid = 1'b1;
                stop_req      = 1'b1;
                @(negedge clk);
                check_idle("post_reset");
                check("post_reset_dec_sel", dec_sel, 0);
                check("post_reset_out_iters", out_iters, 0);
                check("post_reset_timeout_err", timeout_err, 0);
                next_cycle();
                dec_out_valid = 1'b0;
                return;
            end
            frame_valid   = d_fv[o];
            dec_out_valid = d_dov[o];
            stop_req      = d_stop[o];
            @(negedge clk);
            check("frame_ready", frame_ready, o == 0);
            check("busy", busy, o != 0);
            check("dec_in_valid", dec_in_valid, e_div[o]);
            check("apriori_zero", apriori_zero, e_apz[o]);
            check("ext_we", ext_we, e_we[o]);
            check("out_valid", out_valid, o == done_o);
            if (o > 0 && o < done_o) check("dec_sel", dec_sel, e_sel[o]);
            if (o == done_o) begin
                check("out_iters", out_iters, e_iters);
                check("timeout_err", timeout_err, e_to);
            end
            next_cycle();
        end
    endtask

    initial begin
        reset         = 1'b1;
        frame_valid   = 1'b0;
        dec_out_valid = 1'b0;
        stop_req      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check("reset_dec_sel", dec_sel, 0);
        check("reset_out_iters", out_iters, 0);
        check("reset_timeout_err", timeout_err, 0);
        next_cycle();

        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        idle_cycles(2);
        run_frame(5, 1'b1);
        run_frame(5, 1'b1);
        run_frame(4, 1'b0);
        idle_cycles(1);
        run_frame(3, 1'b0);
        run_frame(0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
            run_frame(0, 1'($urandom & 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
